// File: rtl/fetch_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fetch_hazard_ctrl_pkg
// Shared constants for the fetch/hazard control slice: datapath and register
// specifier widths, the halt encoding, and the control FSM state encodings.
// -----------------------------------------------------------------------------
package fetch_hazard_ctrl_pkg;

  localparam int          WORD_W     = 32;
  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] HALT_WORD  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-high clear
//   inc   - add one on this edge (ignored once saturated)
//   count - current count
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (inc && !(&count_reg)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_hazard_ctrl
// Sequences the fetch stage and the IF/ID, ID/EX pipeline registers:
// load-use stall, branch/jump redirect gating with wrong-path squash, a
// halt-drain FSM (RUN -> DRAIN -> DONE) and saturating stall/flush counters.
// Ports:
//   clk, rst                 - clock and synchronous active-high reset
//   id_instr, id_rs, id_rt   - instruction and source specifiers in ID
//   id_uses_rt               - ID instruction reads rt
//   ex_mem_read, ex_rt       - load in EX and its destination register
//   branch_req, jump_req     - redirects resolved in ID
//   pc_stall                 - hold the PC register
//   branch_taken, jump_taken - gated redirects to IF
//   if_id_en, if_id_flush    - IF/ID load enable and clear-to-NOP
//   id_ex_flush              - bubble into ID/EX
//   halt_done                - pipeline drained after halt
//   stall_cnt, flush_cnt     - saturating performance counters
// -----------------------------------------------------------------------------
module fetch_hazard_ctrl
  import fetch_hazard_ctrl_pkg::*;
#(
  parameter int          WORD         = WORD_W,
  parameter int          REG_ADDR     = REG_ADDR_W,
  parameter logic [31:0] HALT_INSTR   = HALT_WORD,
  parameter int          DRAIN_CYCLES = 4,
  parameter int          CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD-1:0]     id_instr,
  input  logic [REG_ADDR-1:0] id_rs,
  input  logic [REG_ADDR-1:0] id_rt,
  input  logic                id_uses_rt,
  input  logic                ex_mem_read,
  input  logic [REG_ADDR-1:0] ex_rt,
  input  logic                branch_req,
  input  logic                jump_req,
  output logic                pc_stall,
  output logic                branch_taken,
  output logic                jump_taken,
  output logic                if_id_en,
  output logic                if_id_flush,
  output logic                id_ex_flush,
  output logic                halt_done,
  output logic [CNT_W-1:0]    stall_cnt,
  output logic [CNT_W-1:0]    flush_cnt
);

  // Drain counter only has to hold DRAIN_CYCLES-1.
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        state_reg;
  logic [DW-1:0] drain_reg;
  logic          done_reg;

  logic halt_det;
  logic load_use;
  logic stall_inc;
  logic flush_inc;

  assign halt_det = (id_instr == WORD'(HALT_INSTR));
  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    // Defaults are also the values forced while rst is high.
    pc_stall     = 1'b0;
    if_id_en     = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    branch_taken = 1'b0;
    jump_taken   = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    if (!rst) begin
      if (state_reg == ST_RUN) begin
        if (halt_det) begin
          pc_stall    = 1'b1;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
        end else if (load_use) begin
          // Branch operands may be stale; the redirect is retried after the stall.
          pc_stall    = 1'b1;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else if (branch_req || jump_req) begin
          jump_taken   = jump_req;
          branch_taken = branch_req && !jump_req;
          if_id_flush  = 1'b1;
          flush_inc    = 1'b1;
        end
      end else begin
        // DRAIN and DONE freeze fetch and keep bubbling ID/EX.
        pc_stall    = 1'b1;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_RUN;
      drain_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      // halt_done is a registered flag, one edge behind entry into DONE.
      done_reg <= (state_reg == ST_DONE);
      case (state_reg)
        ST_RUN: begin
          if (halt_det) begin
            state_reg <= ST_DRAIN;
            drain_reg <= DW'(DRAIN_CYCLES - 1);
          end
        end
        ST_DRAIN: begin
          if (drain_reg == '0) begin
            state_reg <= ST_DONE;
          end else begin
            drain_reg <= drain_reg - 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_DONE;
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign halt_done = done_reg && !rst;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_hazard_ctrl
// Directed plus random stimulus against a small behavioural model of the
// stall/redirect/halt rules, with 4-bit counters so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_fetch_hazard_ctrl;

  localparam int          DC   = 4;
  localparam int          CW   = 4;
  localparam int          CMAX = (1 << CW) - 1;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   id_instr;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, ex_mem_read, branch_req, jump_req;
  logic          pc_stall, branch_taken, jump_taken, if_id_en;
  logic          if_id_flush, id_ex_flush, halt_done;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  fetch_hazard_ctrl #(.DRAIN_CYCLES(DC), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_instr     (id_instr),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .branch_req   (branch_req),
    .jump_req     (jump_req),
    .pc_stall     (pc_stall),
    .branch_taken (branch_taken),
    .jump_taken   (jump_taken),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .halt_done    (halt_done),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  int errors = 0;
  int checks = 0;
  int step_no = 0;

  // Model state: halted since which edge, and plain integer counts.
  bit m_halted = 1'b0;
  int m_since  = 0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step_no, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] instr, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic mr,
                      input logic [4:0] ert, input logic br, input logic jp);
    logic e_pcs, e_en, e_bt, e_jt, e_iff, e_idf, e_done;
    bit halt_now, lu, redir;
    rst = r; id_instr = instr; id_rs = rs; id_rt = rt; id_uses_rt = urt;
    ex_mem_read = mr; ex_rt = ert; branch_req = br; jump_req = jp;
    #1;
    e_pcs = 0; e_en = 1; e_bt = 0; e_jt = 0; e_iff = 0; e_idf = 0;
    halt_now = 0; lu = 0; redir = 0;
    if (!r) begin
      if (m_halted) begin
        e_pcs = 1; e_en = 0; e_idf = 1;
      end else if (instr == HALT) begin
        e_pcs = 1; e_en = 0; e_idf = 1; halt_now = 1;
      end else if (mr && ert != 0 && (ert == rs || (urt && ert == rt))) begin
        e_pcs = 1; e_en = 0; e_idf = 1; lu = 1;
      end else if (br || jp) begin
        e_jt = jp; e_bt = br && !jp; e_iff = 1; redir = 1;
      end
    end
    e_done = !r && m_halted && (m_since >= DC + 1);
    chk("pc_stall", 32'(pc_stall), 32'(e_pcs));
    chk("if_id_en", 32'(if_id_en), 32'(e_en));
    chk("branch_taken", 32'(branch_taken), 32'(e_bt));
    chk("jump_taken", 32'(jump_taken), 32'(e_jt));
    chk("if_id_flush", 32'(if_id_flush), 32'(e_iff));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
    chk("halt_done", 32'(halt_done), 32'(e_done));
    chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
    $display("step %0d rst=%0b instr=%08h rs=%0d rt=%0d urt=%0b mr=%0b ex_rt=%0d br=%0b jp=%0b -> stall=%0b bt=%0b jt=%0b iff=%0b done=%0b sc=%0d fc=%0d",
             step_no, r, instr, rs, rt, urt, mr, ert, br, jp,
             pc_stall, branch_taken, jump_taken, if_id_flush, halt_done, stall_cnt, flush_cnt);
    @(posedge clk);
    #1;
    step_no++;
    if (r) begin
      m_halted = 0; m_since = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (m_halted) m_since++;
      if (halt_now) begin m_halted = 1; m_since = 0; end
      if (lu && m_stall < CMAX) m_stall++;
      if (redir && m_flush < CMAX) m_flush++;
    end
  endtask

  initial begin
    logic        r_rnd;
    logic [31:0] i_rnd;

    // Reset
    step(1, NOP, 0, 0, 0, 0, 0, 0, 0);
    step(1, NOP, 0, 0, 0, 0, 0, 0, 0);
    // Load-use on rs, then clear
    step(0, NOP, 5, 1, 0, 1, 5, 0, 0);
    step(0, NOP, 5, 1, 0, 0, 5, 0, 0);
    chk("stall_cnt_after_lu", 32'(stall_cnt), 32'd1);
    // Load to r0 never stalls
    step(0, NOP, 0, 0, 1, 1, 0, 0, 0);
    // Load-use through rt only when rt is a source
    step(0, NOP, 1, 7, 0, 1, 7, 0, 0);
    step(0, NOP, 1, 7, 1, 1, 7, 0, 0);
    // Branch, then branch+jump
    step(0, NOP, 1, 2, 0, 0, 0, 1, 0);
    step(0, NOP, 1, 2, 0, 0, 0, 1, 1);
    step(0, NOP, 1, 2, 0, 0, 0, 0, 1);
    // Branch under load-use, then retried
    step(0, NOP, 3, 2, 0, 1, 3, 1, 0);
    step(0, NOP, 3, 2, 0, 0, 3, 1, 0);
    step(0, NOP, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_cnt_directed", 32'(flush_cnt), 32'd4);
    chk("stall_cnt_directed", 32'(stall_cnt), 32'd3);
    // Halt with redirect and hazard present; drain and hold DONE
    step(0, HALT, 3, 2, 1, 1, 3, 1, 1);
    for (int k = 0; k < 8; k++) step(0, NOP, 3, 3, 1, 1, 3, 1, 0);
    chk("halt_done_held", 32'(halt_done), 32'd1);
    // Reset mid-drain
    step(1, NOP, 0, 0, 0, 0, 0, 0, 0);
    step(0, HALT, 0, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 0, 0, 0, 0, 0, 0, 0);
    step(0, NOP, 0, 0, 0, 0, 0, 0, 0);
    step(1, NOP, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, NOP, 0, 0, 0, 0, 0, 0, 0);
    chk("halt_done_after_rst", 32'(halt_done), 32'd0);
    // Saturation: 20 stall cycles on a 4-bit counter
    for (int k = 0; k < 20; k++) step(0, NOP, 9, 0, 0, 1, 9, 0, 0);
    chk("stall_cnt_saturated", 32'(stall_cnt), 32'hF);
    // Random
    for (int k = 0; k < 300; k++) begin
      r_rnd = ($urandom_range(0, 63) == 0) || (m_halted && $urandom_range(0, 9) == 0);
      i_rnd = ($urandom_range(0, 40) == 0) ? HALT : $urandom;
      step(r_rnd, i_rnd, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
